// File: rtl/data_bus_if.sv
// data_bus_if: CPU data-bus transaction and read-return signals
interface data_bus_if;
    logic        cs;
    logic        wr_rd;
    logic [15:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        rd_valid;
    modport master (output cs, wr_rd, ADDR, Data_BUS_WRITE, input Data_BUS_READ, rd_valid);
    modport slave (input cs, wr_rd, ADDR, Data_BUS_WRITE, output Data_BUS_READ, rd_valid);
endinterface

// File: rtl/data_bus_responder.sv
// data_bus_responder: data RAM plus counter/scratch/status registers with fixed-latency read return
module data_bus_responder #(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [15:0] MMIO_BASE    = 16'hFF00,
    parameter logic [31:0] OOR_DATA     = 32'hDEADBEEF
) (
    input  logic       CLK,
    input  logic       reset,
    data_bus_if.slave  bus
);
    localparam int AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int LAST = int'(READ_LATENCY) - 1;

    logic [31:0]             r_ram [MEM_WORDS];
    logic [31:0]             r_cycle_cnt;
    logic [31:0]             r_wr_cnt;
    logic [31:0]             r_scratch;
    logic                    r_err;
    logic [31:0]             r_pd [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_pv;

    logic                    w_mem;
    logic                    w_mmio;
    logic                    w_oor;
    logic                    w_wr;
    logic                    w_rd;
    logic [15:0]             w_off;
    logic [AW-1:0]           w_ma;
    logic [31:0]             w_mmio_data;
    logic [31:0]             w_rdata;
    logic [READ_LATENCY-1:0] w_vin;
    logic [31:0]             w_din [READ_LATENCY];

    // RAM takes precedence over the register window if they ever overlap
    assign w_mem       = 32'(bus.ADDR) < MEM_WORDS;
    assign w_off       = bus.ADDR - MMIO_BASE;
    assign w_mmio      = !w_mem && (w_off < 16'd4);
    assign w_oor       = !w_mem && !w_mmio;
    assign w_wr        = bus.cs && bus.wr_rd && !reset;
    assign w_rd        = bus.cs && !bus.wr_rd && !reset;
    assign w_ma        = bus.ADDR[AW-1:0];
    assign w_mmio_data = (w_off[1:0] == 2'd0) ? r_cycle_cnt :
                         (w_off[1:0] == 2'd1) ? r_wr_cnt :
                         (w_off[1:0] == 2'd2) ? r_scratch : {31'b0, r_err};
    assign w_rdata     = w_mem ? r_ram[w_ma] : (w_mmio ? w_mmio_data : OOR_DATA);

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge CLK) begin
        if (w_wr && w_mem) r_ram[w_ma] <= bus.Data_BUS_WRITE;
    end

    // Counters, scratch and sticky error flag (an OOR access beats a clear)
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_wr_cnt    <= '0;
            r_scratch   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_wr && w_mem) r_wr_cnt <= r_wr_cnt + 32'd1;
            else if (w_wr && w_mmio && w_off[1:0] == 2'd1) r_wr_cnt <= bus.Data_BUS_WRITE;
            if (w_wr && w_mmio && w_off[1:0] == 2'd2) r_scratch <= bus.Data_BUS_WRITE;
            if (bus.cs && w_oor) r_err <= 1'b1;
            else if (w_wr && w_mmio && w_off[1:0] == 2'd3 && bus.Data_BUS_WRITE[0]) r_err <= 1'b0;
        end
    end

    // Inputs to each pipeline stage: stage 0 takes the freshly captured read
    always_comb begin
        w_vin[0] = w_rd;
        w_din[0] = w_rdata;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            w_vin[i] = r_pv[i-1];
            w_din[i] = r_pd[i-1];
        end
    end

    // Read pipeline; the last stage only loads on a valid read so the output holds
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pv <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) r_pd[i] <= '0;
        end else begin
            r_pv <= w_vin;
            for (int i = 0; i < int'(READ_LATENCY); i++)
                if (w_vin[i] || i != LAST) r_pd[i] <= w_din[i];
        end
    end

    assign bus.Data_BUS_READ = r_pd[LAST];
    assign bus.rd_valid      = r_pv[LAST];
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: directed checks on latency-1, -2 and -3 responders driven in lockstep
module tb_data_bus_responder;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        wr_rd = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] c1;
    logic [31:0] c2;

    always #5 CLK = ~CLK;

    data_bus_if b1 ();
    data_bus_if b2 ();
    data_bus_if b3 ();

    assign b1.cs = cs;  assign b1.wr_rd = wr_rd;  assign b1.ADDR = addr;  assign b1.Data_BUS_WRITE = wdata;
    assign b2.cs = cs;  assign b2.wr_rd = wr_rd;  assign b2.ADDR = addr;  assign b2.Data_BUS_WRITE = wdata;
    assign b3.cs = cs;  assign b3.wr_rd = wr_rd;  assign b3.ADDR = addr;  assign b3.Data_BUS_WRITE = wdata;

    data_bus_responder #(.READ_LATENCY(1)) u1 (.CLK(CLK), .reset(reset), .bus(b1));
    data_bus_responder #(.READ_LATENCY(2)) u2 (.CLK(CLK), .reset(reset), .bus(b2));
    data_bus_responder #(.READ_LATENCY(3)) u3 (.CLK(CLK), .reset(reset), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic w, input logic [15:0] a, input logic [31:0] d);
        cs = c; wr_rd = w; addr = a; wdata = d;
        @(posedge CLK);
        #1;
        cs = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    initial begin
        repeat (3) idle();
        chk("rst_d1", b1.Data_BUS_READ, 32'h0);
        chk("rst_v1", 32'(b1.rd_valid), 32'h0);
        chk("rst_v2", 32'(b2.rd_valid), 32'h0);
        chk("rst_v3", 32'(b3.rd_valid), 32'h0);
        reset = 1'b0;

        wr(16'h0010, 32'h12345678);
        rd(16'h0010);
        chk("raw_v", 32'(b1.rd_valid), 32'h1);
        chk("raw_d", b1.Data_BUS_READ, 32'h12345678);
        idle();
        chk("bubble_v", 32'(b1.rd_valid), 32'h0);
        chk("hold_d", b1.Data_BUS_READ, 32'h12345678);
        rd(16'hFF01);
        chk("wrcnt1", b1.Data_BUS_READ, 32'h1);

        wr(16'h0001, 32'hA);
        wr(16'h0002, 32'hB);
        wr(16'h0003, 32'hC);
        rd(16'h0001);
        chk("l3_c1_v", 32'(b3.rd_valid), 32'h0);
        chk("l1_a", b1.Data_BUS_READ, 32'hA);
        rd(16'h0002);
        chk("l3_c2_v", 32'(b3.rd_valid), 32'h0);
        rd(16'h0003);
        chk("l3_a_v", 32'(b3.rd_valid), 32'h1);
        chk("l3_a_d", b3.Data_BUS_READ, 32'hA);
        idle();
        chk("l3_b_v", 32'(b3.rd_valid), 32'h1);
        chk("l3_b_d", b3.Data_BUS_READ, 32'hB);
        idle();
        chk("l3_c_v", 32'(b3.rd_valid), 32'h1);
        chk("l3_c_d", b3.Data_BUS_READ, 32'hC);
        idle();
        chk("l3_end_v", 32'(b3.rd_valid), 32'h0);
        chk("l3_hold", b3.Data_BUS_READ, 32'hC);

        rd(16'h8000);
        chk("oor_rd", b1.Data_BUS_READ, 32'hDEADBEEF);
        rd(16'hFF03);
        chk("err_set", b1.Data_BUS_READ, 32'h1);
        wr(16'hFF03, 32'h1);
        rd(16'hFF03);
        chk("err_clr", b1.Data_BUS_READ, 32'h0);
        wr(16'h8000, 32'h77);
        rd(16'hFF01);
        chk("oor_wr_cnt", b1.Data_BUS_READ, 32'h4);
        rd(16'hFF03);
        chk("oor_wr_err", b1.Data_BUS_READ, 32'h1);
        rd(16'hFF04);
        chk("mmio_end", b1.Data_BUS_READ, 32'hDEADBEEF);

        wr(16'hFF01, 32'hFFFFFFFF);
        rd(16'hFF01);
        chk("wrcnt_load", b1.Data_BUS_READ, 32'hFFFFFFFF);
        wr(16'h0005, 32'h55);
        rd(16'hFF01);
        chk("wrcnt_wrap", b1.Data_BUS_READ, 32'h0);
        rd(16'h0005);
        chk("mem5", b1.Data_BUS_READ, 32'h55);
        wr(16'hFF02, 32'h5A5A5A5A);
        rd(16'hFF02);
        chk("scratch", b1.Data_BUS_READ, 32'h5A5A5A5A);

        rd(16'hFF00);
        c1 = b1.Data_BUS_READ;
        wr(16'hFF00, 32'h0);
        repeat (8) idle();
        rd(16'hFF00);
        c2 = b1.Data_BUS_READ;
        chk("cyc_delta", c2 - c1, 32'd10);

        rd(16'h0010);
        reset = 1'b1;
        wr(16'h0010, 32'h00000BAD);
        reset = 1'b0;
        chk("abort_v2", 32'(b2.rd_valid), 32'h0);
        chk("abort_d2", b2.Data_BUS_READ, 32'h0);
        rd(16'hFF00);
        chk("abort_v2b", 32'(b2.rd_valid), 32'h0);
        chk("post_cyc", b1.Data_BUS_READ, 32'h0);
        rd(16'hFF01);
        chk("post_wrcnt", b1.Data_BUS_READ, 32'h0);
        chk("l2_v", 32'(b2.rd_valid), 32'h1);
        chk("l2_d", b2.Data_BUS_READ, 32'h0);
        rd(16'hFF02);
        chk("post_scr", b1.Data_BUS_READ, 32'h0);
        rd(16'hFF03);
        chk("post_err", b1.Data_BUS_READ, 32'h0);
        rd(16'h0010);
        chk("ram_kept", b1.Data_BUS_READ, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Bus responder (slave) for the CPU data bus: accepts single-cycle cs/wr_rd/ADDR transactions issued by the CPU.
- Serves a word-addressed data RAM plus a small memory-mapped register window: cycle counter, write counter, scratch register, error status.
- Returns read data on Data_BUS_READ with a fixed, parameterised latency.
- Sits beside the CPU at top level; the CPU's Data_BUS_WRITE is its input, and its Data_BUS_READ feeds the CPU.

Parameters:
- MEM_WORDS, 1024: number of 32-bit RAM words; legal range 1..65280.
- READ_LATENCY, 1: cycles from the cs cycle to valid read data; legal range 1..4.
- MMIO_BASE, 16'hFF00: base word address of the register window.
- OOR_DATA, 32'hDEADBEEF: value returned for out-of-range reads.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cs  input  1  transaction strobe, one transaction per cycle while high
- wr_rd  input  1  1 = write, 0 = read; sampled only when cs=1
- ADDR  input  16  word address
- Data_BUS_WRITE  input  32  write data, sampled with cs=1, wr_rd=1
- Data_BUS_READ  output  32  read data
- rd_valid  output  1  one-cycle pulse marking fresh Data_BUS_READ

Behaviour:
- Clocking and reset:
  - One clock (CLK). Reset is synchronous and active-high on `reset`.
  - Reset values: Data_BUS_READ=0, rd_valid=0, cycle_cnt=0, wr_cnt=0, scratch=0, err=0, read pipeline flushed.
  - RAM contents are not reset.
- Address decode (every edge with cs=1):
  - MEM: ADDR < MEM_WORDS.
  - MMIO: MMIO_BASE..MMIO_BASE+3.
  - OOR: everything else, including MMIO_BASE+4..16'hFFFF.
- Writes (cs=1, wr_rd=1):
  - Take effect at the edge of the cs cycle.
  - MEM write: RAM[ADDR] <= Data_BUS_WRITE; wr_cnt increments (32-bit, wraps 0xFFFFFFFF->0).
  - MMIO+0 (cycle_cnt): read-only, write ignored.
  - MMIO+1 (wr_cnt): write loads wr_cnt.
  - MMIO+2 (scratch): write loads scratch.
  - MMIO+3 (status): write with bit0=1 clears err; other bits ignored.
  - OOR write: data dropped, err <= 1.
  - MMIO writes do not increment wr_cnt.
- Reads (cs=1, wr_rd=0):
  - Read value is captured at the edge of the cs cycle.
  - A read issued the cycle after a write to the same address returns the new data.
  - cycle_cnt reads return the value held during the cs cycle.
  - Status reads return {31'b0, err}.
  - OOR read returns OOR_DATA and sets err <= 1.
- Read latency pipeline:
  - Captured value passes through a READ_LATENCY-deep shift pipeline with a valid bit per stage.
  - For a read in cycle N, Data_BUS_READ is updated and rd_valid=1 in cycle N+READ_LATENCY.
  - Data_BUS_READ holds its value until the next read completes; rd_valid is high for exactly one cycle per read.
  - Back-to-back reads give back-to-back rd_valid pulses, in order.
  - Writes and idle cycles insert bubbles (rd_valid=0).
- cycle_cnt: free-running 32-bit counter, +1 every cycle out of reset, wraps to 0.
- Simultaneous events:
  - A write to MMIO+3 clearing err in the same cycle as an OOR access: set wins, err=1.
  - A MEM write while wr_cnt=0xFFFFFFFF gives wr_cnt=0.
  - Writing MMIO+1 loads the written value; the write itself does not increment.
- Reset mid-operation: all in-flight reads are discarded and rd_valid stays 0 for them. A transaction presented in the reset cycle is ignored (no RAM write, no counter change).
- cs=0: no state change except cycle_cnt and pipeline advance.

Test Plan:
- Reset, then write 0x12345678 to ADDR 0x0010, read ADDR 0x0010 next cycle (READ_LATENCY=1) -> rd_valid pulse one cycle after the read, Data_BUS_READ=0x12345678, wr_cnt reads 1.
- READ_LATENCY=3, reads of ADDR 1, 2, 3 on consecutive cycles after writing 0xA, 0xB, 0xC there -> three consecutive rd_valid pulses starting 3 cycles after the first read, data 0xA, 0xB, 0xC in order.
- Read ADDR 0x8000 (MEM_WORDS=1024) -> Data_BUS_READ=0xDEADBEEF; status read returns 1; write 0x1 to 0xFF03 -> status reads 0. Write to 0x8000 leaves wr_cnt unchanged.
- Write 0xFFFFFFFF to 0xFF01, then a MEM write -> wr_cnt reads 0. Write 0x5A5A5A5A to 0xFF02 -> reads back 0x5A5A5A5A. Write to 0xFF00 ignored.
- Reads of 0xFF00 exactly 10 cycles apart -> returned values differ by exactly 10.
- READ_LATENCY=2: issue a read, assert reset the next cycle -> no rd_valid pulse. Data_BUS_READ=0, and 0xFF00/0xFF01/0xFF02/0xFF03 all read 0 right after release.
